arf132b256e1r1w0cbbehcaa4acw_acc_ctl: RTL and testbench



---
 rtl/arf132b256e1r1w0cbbehcaa4acw_pkg.sv | 18 +
 rtl/arf132b256e1r1w0cbbehcaa4acw_acc_ctl_if.sv | 37 +++
 rtl/arf132b256e1r1w0cbbehcaa4acw_rr_arb2.sv | 32 +++
 rtl/arf132b256e1r1w0cbbehcaa4acw_acc_ctl.sv | 125 ++++++++++++
 tb/tb_arf132b256e1r1w0cbbehcaa4acw_acc_ctl.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_pkg.sv
// Shared constants and types for the 132x256 1R1W register file access controller.
package arf132b256e1r1w0cbbehcaa4acw_pkg;

    localparam int WIDTH = 132;
    localparam int DEPTH = 256;
    localparam int AW    = $clog2(DEPTH);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    typedef struct packed {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_acc_ctl_if.sv
// Requester-side bus of the access controller: two write requesters and one reader.
interface arf132b256e1r1w0cbbehcaa4acw_acc_ctl_if;
    import arf132b256e1r1w0cbbehcaa4acw_pkg::*;

    logic             wa_valid;
    logic             wa_ready;
    logic [AW-1:0]    wa_addr;
    logic [WIDTH-1:0] wa_data;
    logic             wb_valid;
    logic             wb_ready;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [AW-1:0]    rd_addr;
    logic             rd_rsp_valid;
    logic [WIDTH-1:0] rd_rsp_data;

    modport master (
        output wa_valid, wa_addr, wa_data,
        input  wa_ready,
        output wb_valid, wb_addr, wb_data,
        input  wb_ready,
        output rd_valid, rd_addr,
        input  rd_ready, rd_rsp_valid, rd_rsp_data
    );

    modport slave (
        input  wa_valid, wa_addr, wa_data,
        output wa_ready,
        input  wb_valid, wb_addr, wb_data,
        output wb_ready,
        input  rd_valid, rd_addr,
        output rd_ready, rd_rsp_valid, rd_rsp_data
    );

endinterface

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_rr_arb2.sv
// Two-requester round-robin arbiter; the pointer only moves after a contested grant.
module arf132b256e1r1w0cbbehcaa4acw_rr_arb2
    import arf132b256e1r1w0cbbehcaa4acw_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    // ptr_q = 0 favours requester 0 (A), 1 favours requester 1 (B)
    logic ptr_q;
    logic ptr_d;

    always_comb begin
        grant = valid;
        ptr_d = ptr_q;
        if (&valid) begin
            grant = ptr_q ? 2'b10 : 2'b01;
            ptr_d = ~ptr_q;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/arf132b256e1r1w0cbbehcaa4acw_acc_ctl.sv
// Access controller: init sweep, round-robin write port arbitration, 1-cycle read with write bypass.
module arf132b256e1r1w0cbbehcaa4acw_acc_ctl
    import arf132b256e1r1w0cbbehcaa4acw_pkg::*;
#(
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                                     clk,
    input  logic                                     rstb,
    input  logic                                     init_start,
    output logic                                     init_done,
    arf132b256e1r1w0cbbehcaa4acw_acc_ctl_if.slave    req,
    output logic                                     arf_wr_en,
    output logic [AW-1:0]                            arf_wr_addr,
    output logic [WIDTH-1:0]                         arf_wr_data,
    output logic                                     arf_rd_en,
    output logic [AW-1:0]                            arf_rd_addr,
    input  logic [WIDTH-1:0]                         arf_rd_data
);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             bypass_q, bypass_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;

    logic             run;
    logic [1:0]       arb_valid;
    logic [1:0]       grant;
    logic             wr_grant;
    logic             rd_accept;
    wr_req_t          wr_sel;

    assign run       = (state_q == ST_RUN);
    assign arb_valid = {req.wb_valid, req.wa_valid} & {2{run}};
    assign wr_grant  = |grant;

    arf132b256e1r1w0cbbehcaa4acw_rr_arb2 u_arb (
        .clk   (clk),
        .rstb  (rstb),
        .valid (arb_valid),
        .grant (grant)
    );

    assign req.wa_ready = grant[0];
    assign req.wb_ready = grant[1];

    always_comb begin
        if (grant[1]) begin
            wr_sel.addr = req.wb_addr;
            wr_sel.data = req.wb_data;
        end else begin
            wr_sel.addr = req.wa_addr;
            wr_sel.data = req.wa_data;
        end
    end

    // The sweep write is qualified with rstb so the array sees no write while reset is held.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done   = 1'b0;
        arf_wr_en   = 1'b0;
        arf_wr_addr = '0;
        arf_wr_data = '0;
        case (state_q)
            ST_INIT: begin
                arf_wr_en   = rstb;
                arf_wr_addr = cnt_q;
                arf_wr_data = INIT_VAL;
                cnt_d       = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                init_done = 1'b1;
                if (wr_grant) begin
                    arf_wr_en   = 1'b1;
                    arf_wr_addr = wr_sel.addr;
                    arf_wr_data = wr_sel.data;
                end
                if (init_start) begin
                    state_d = ST_INIT;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign req.rd_ready = run;
    assign rd_accept    = run & req.rd_valid;
    assign arf_rd_en    = rd_accept;
    assign arf_rd_addr  = rd_accept ? req.rd_addr : '0;

    // A same-cycle write to the read address wins over the array's stale read data.
    always_comb begin
        rsp_valid_d = rd_accept;
        bypass_d    = rd_accept & wr_grant & (wr_sel.addr == req.rd_addr);
        wdata_d     = bypass_d ? wr_sel.data : wdata_q;
    end

    assign req.rd_rsp_valid = rsp_valid_q;
    assign req.rd_rsp_data  = rsp_valid_q ? (bypass_q ? wdata_q : arf_rd_data) : '0;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            bypass_q    <= 1'b0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            bypass_q    <= bypass_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: tb/tb_arf132b256e1r1w0cbbehcaa4acw_acc_ctl.sv
// Randomized bench for the access controller, checked against a transaction-level model of the array.
module tb_arf132b256e1r1w0cbbehcaa4acw_acc_ctl;
    import arf132b256e1r1w0cbbehcaa4acw_pkg::*;

    localparam logic [WIDTH-1:0] TB_INIT_VAL = {4'h5, {16{8'hC3}}};

    logic             clk = 1'b0;
    logic             rstb = 1'b1;
    logic             init_start = 1'b0;
    logic             init_done;
    logic             arf_wr_en;
    logic [AW-1:0]    arf_wr_addr;
    logic [WIDTH-1:0] arf_wr_data;
    logic             arf_rd_en;
    logic [AW-1:0]    arf_rd_addr;
    logic [WIDTH-1:0] arf_rd_data;

    arf132b256e1r1w0cbbehcaa4acw_acc_ctl_if bus ();

    arf132b256e1r1w0cbbehcaa4acw_acc_ctl #(
        .INIT_VAL (TB_INIT_VAL)
    ) dut (
        .clk         (clk),
        .rstb        (rstb),
        .init_start  (init_start),
        .init_done   (init_done),
        .req         (bus),
        .arf_wr_en   (arf_wr_en),
        .arf_wr_addr (arf_wr_addr),
        .arf_wr_data (arf_wr_data),
        .arf_rd_en   (arf_rd_en),
        .arf_rd_addr (arf_rd_addr),
        .arf_rd_data (arf_rd_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the real 1R1W array: write at the edge, registered read returning old contents.
    logic [WIDTH-1:0] arr [DEPTH];
    always @(posedge clk) begin
        if (arf_wr_en) arr[arf_wr_addr] <= arf_wr_data;
        if (arf_rd_en) arf_rd_data <= arr[arf_rd_addr];
    end

    int compared = 0;
    int mismatched = 0;

    // Reference model: sweep progress, arbitration preference, expected array contents, pending response.
    bit               m_init = 1'b1;
    int               m_idx = 0;
    bit               m_ptr = 1'b0;
    logic [WIDTH-1:0] m_mem [DEPTH];
    bit               m_rsp_v = 1'b0;
    logic [WIDTH-1:0] m_rsp_d = '0;

    task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] randData();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return t[WIDTH-1:0];
    endfunction

    function automatic logic [AW-1:0] randAddr();
        logic [31:0] t;
        t = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom_range(0, DEPTH - 1));
        return t[AW-1:0];
    endfunction

    // One clock cycle: drive inputs, check every output against the model, then advance the model.
    task automatic applyStimulus(input bit wav, input logic [AW-1:0] waa, input logic [WIDTH-1:0] wad,
                                 input bit wbv, input logic [AW-1:0] wba, input logic [WIDTH-1:0] wbd,
                                 input bit rdv, input logic [AW-1:0] rda, input bit ist);
        int               g;
        bit               e_wr_en;
        logic [AW-1:0]    e_wr_addr;
        logic [WIDTH-1:0] e_wr_data;
        bit               n_rsp_v;
        logic [WIDTH-1:0] n_rsp_d;

        bus.wa_valid = wav; bus.wa_addr = waa; bus.wa_data = wad;
        bus.wb_valid = wbv; bus.wb_addr = wba; bus.wb_data = wbd;
        bus.rd_valid = rdv; bus.rd_addr = rda; init_start = ist;
        #1;

        g = -1;
        e_wr_en = 1'b0;
        e_wr_addr = '0;
        e_wr_data = '0;
        if (m_init) begin
            e_wr_en = 1'b1;
            e_wr_addr = m_idx[AW-1:0];
            e_wr_data = TB_INIT_VAL;
        end else begin
            if (wav && wbv) g = m_ptr ? 1 : 0;
            else if (wav) g = 0;
            else if (wbv) g = 1;
            if (g == 0) begin e_wr_en = 1'b1; e_wr_addr = waa; e_wr_data = wad; end
            if (g == 1) begin e_wr_en = 1'b1; e_wr_addr = wba; e_wr_data = wbd; end
        end

        checkOutput("init_done", WIDTH'(init_done), WIDTH'(!m_init));
        checkOutput("wa_ready", WIDTH'(bus.wa_ready), WIDTH'(g == 0));
        checkOutput("wb_ready", WIDTH'(bus.wb_ready), WIDTH'(g == 1));
        checkOutput("rd_ready", WIDTH'(bus.rd_ready), WIDTH'(!m_init));
        checkOutput("arf_wr_en", WIDTH'(arf_wr_en), WIDTH'(e_wr_en));
        if (e_wr_en) begin
            checkOutput("arf_wr_addr", WIDTH'(arf_wr_addr), WIDTH'(e_wr_addr));
            checkOutput("arf_wr_data", arf_wr_data, e_wr_data);
        end
        checkOutput("arf_rd_en", WIDTH'(arf_rd_en), WIDTH'(!m_init && rdv));
        if (!m_init && rdv) checkOutput("arf_rd_addr", WIDTH'(arf_rd_addr), WIDTH'(rda));
        checkOutput("rd_rsp_valid", WIDTH'(bus.rd_rsp_valid), WIDTH'(m_rsp_v));
        if (m_rsp_v) checkOutput("rd_rsp_data", bus.rd_rsp_data, m_rsp_d);

        n_rsp_v = !m_init && rdv;
        n_rsp_d = (g >= 0 && e_wr_addr == rda) ? e_wr_data : m_mem[rda];
        if (e_wr_en) m_mem[e_wr_addr] = e_wr_data;
        if (!m_init && wav && wbv) m_ptr = !m_ptr;
        if (m_init) begin
            m_idx++;
            if (m_idx == DEPTH) m_init = 1'b0;
        end else if (ist) begin
            m_init = 1'b1;
            m_idx = 0;
        end
        m_rsp_v = n_rsp_v;
        m_rsp_d = n_rsp_d;

        @(posedge clk);
        #1;
    endtask

    task automatic applyIdle();
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic applyRandom(input int initPct);
        applyStimulus($urandom_range(0, 1) == 1, randAddr(), randData(),
                      $urandom_range(0, 1) == 1, randAddr(), randData(),
                      $urandom_range(0, 2) != 0, randAddr(),
                      $urandom_range(0, 99) < initPct);
    endtask

    // Asynchronous reset in the middle of a cycle; outputs must clear without waiting for an edge.
    task automatic applyReset();
        rstb = 1'b0;
        bus.wa_valid = 1'b0; bus.wb_valid = 1'b0; bus.rd_valid = 1'b0; init_start = 1'b0;
        #1;
        checkOutput("rst_init_done", WIDTH'(init_done), '0);
        checkOutput("rst_wa_ready", WIDTH'(bus.wa_ready), '0);
        checkOutput("rst_wb_ready", WIDTH'(bus.wb_ready), '0);
        checkOutput("rst_rd_ready", WIDTH'(bus.rd_ready), '0);
        checkOutput("rst_rsp_valid", WIDTH'(bus.rd_rsp_valid), '0);
        checkOutput("rst_rsp_data", bus.rd_rsp_data, '0);
        checkOutput("rst_arf_wr_en", WIDTH'(arf_wr_en), '0);
        checkOutput("rst_arf_rd_en", WIDTH'(arf_rd_en), '0);
        checkOutput("rst_arf_wr_addr", WIDTH'(arf_wr_addr), '0);
        checkOutput("rst_arf_rd_addr", WIDTH'(arf_rd_addr), '0);
        m_init = 1'b1;
        m_idx = 0;
        m_ptr = 1'b0;
        m_rsp_v = 1'b0;
        @(posedge clk);
        #1;
        rstb = 1'b1;
    endtask

    initial begin
        logic [WIDTH-1:0] da;
        logic [WIDTH-1:0] db;

        bus.wa_valid = 1'b0; bus.wa_addr = '0; bus.wa_data = '0;
        bus.wb_valid = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
        bus.rd_valid = 1'b0; bus.rd_addr = '0;

        @(posedge clk);
        #1;
        applyReset();
        $display("[TB] initial sweep");
        repeat (DEPTH) applyIdle();
        applyIdle();

        $display("[TB] contested writes with a lone B request in between");
        da = randData();
        db = randData();
        applyStimulus(1'b1, 8'h10, da, 1'b1, 8'h20, db, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'h10, db, 1'b1, 8'h20, da, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, 8'h10, da, 1'b1, 8'h21, db, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'h11, da, 1'b1, 8'h20, db, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 8'h10, db, 1'b1, 8'h22, da, 1'b0, '0, 1'b0);

        $display("[TB] write then read, and same-cycle bypass");
        applyStimulus(1'b1, 8'd5, WIDTH'(12'hABC), 1'b0, '0, '0, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 8'd5, 1'b0);
        applyStimulus(1'b1, 8'd7, WIDTH'(12'h123), 1'b0, '0, '0, 1'b1, 8'd7, 1'b0);
        applyStimulus(1'b1, 8'd7, WIDTH'(12'h456), 1'b0, '0, '0, 1'b1, 8'd8, 1'b0);
        applyStimulus(1'b0, '0, '0, 1'b1, 8'd9, randData(), 1'b1, 8'd9, 1'b0);
        applyIdle();

        $display("[TB] random traffic");
        repeat (400) applyRandom(2);

        $display("[TB] re-init while streaming");
        while (m_init) applyRandom(0);
        repeat (5) applyRandom(0);
        applyStimulus(1'b1, randAddr(), randData(), 1'b1, randAddr(), randData(), 1'b1, 8'd3, 1'b1);
        repeat (DEPTH + 8) applyRandom(25);

        $display("[TB] reset in the middle of a sweep");
        while (m_init) applyRandom(0);
        applyStimulus(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 8'd1, 1'b1);
        repeat (100) applyRandom(0);
        applyReset();
        repeat (DEPTH + 4) applyRandom(0);
        repeat (300) applyRandom(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
